fifo_access_arbiter: RTL and testbench
======================================

Name: fifo_access_arbiter

Overview:
- Shares one FIFO counter/storage resource between NREQ producers and NREQ consumers.
- Each cycle it grants at most one push and at most one pop, using independent round-robin arbiters.
- Tracks occupancy internally and drives the FIFO's single push/pop strobes.
- Never grants a push into a full FIFO or a pop from an empty FIFO.

Parameters:
- NREQ, 4: number of push requesters and number of pop requesters (2..16).
- MAXCOUNT, 8: FIFO depth in entries.
- CW, $clog2(MAXCOUNT+1): width of fifo_count (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- push_req  input  NREQ  per-producer push request; level, held until granted.
- pop_req  input  NREQ  per-consumer pop request; level, held until granted.
- push_gnt  output  NREQ  one-hot-or-zero push grant, same cycle as request.
- pop_gnt  output  NREQ  one-hot-or-zero pop grant, same cycle as request.
- push  output  1  FIFO push strobe; equals OR of push_gnt.
- pop  output  1  FIFO pop strobe; equals OR of pop_gnt.
- push_idx  output  $clog2(NREQ)  index of the granted producer; 0 when push=0.
- pop_idx  output  $clog2(NREQ)  index of the granted consumer; 0 when pop=0.
- full  output  1  fifo_count == MAXCOUNT.
- empty  output  1  fifo_count == 0.
- fifo_count  output  CW  current occupancy.

Behaviour:
- Reset (async assert, sync-free release):
  - fifo_count=0, full=0, empty=1.
  - Both round-robin pointers = 0.
  - All grants, push, pop, push_idx and pop_idx forced to 0 while rst=1.
- Eligibility (combinational, from registered state):
  - pop_ok = !empty.
  - push_ok = !full OR (pop_ok AND |pop_req). A push into a full FIFO is legal only when a pop is granted the same cycle.
- Arbitration:
  - Grants are combinational, zero latency.
  - Each arbiter searches from its pointer upward, wrapping at NREQ-1 → 0. The first asserted request wins.
  - Grants are suppressed entirely when the corresponding _ok is 0.
- Pointer update (clocked): on a grant, the pointer becomes winner+1 mod NREQ. With no grant, the pointer holds.
- Count update (clocked):
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - Neither: hold.
- Saturation: the count never exceeds MAXCOUNT and never underflows; the eligibility rules guarantee this, with no wrap.
- Handshake: a requester whose request is not granted keeps it asserted. Dropping a request before grant is allowed and has no side effect.
- Fairness: with all NREQ requesters continuously active, each is granted exactly once every NREQ grants.
- Empty with push and pop both requested: only the push is granted; the count becomes 1.
- Full with push and pop both requested: both are granted; the count stays MAXCOUNT.
- Reset asserted mid-operation: grants drop immediately (asynchronously) and state clears; the first grant after release starts from index 0.

Optional Feature:
- Macro FIFO_ARB_CHECK_EN.
- When defined, the clocked block contains immediate assertions:
  - push_gnt and pop_gnt each one-hot-or-zero.
  - fifo_count <= MAXCOUNT.
  - No push when full without a pop.
  - No pop when empty.
- Also when defined: cover statements for full reached, empty after full, simultaneous push+pop at full, and pointer wrap. Failures report via $error with %m and $time.
- When undefined, none of these are compiled. Functional behaviour and port list are identical either way.

Decomposition:
- Package fifo_arb_pkg holds NREQ/MAXCOUNT defaults and typedefs req_vec_t (logic [NREQ-1:0]) and idx_t.
- Sub-module rr_arbiter provides a single round-robin arbiter: req, enable, and pointer register in; grant, index, and valid out. It is instantiated twice, once for push and once for pop.
- Occupancy counter and eligibility logic live in the top level.

Test Plan:
- Reset with all requests high → all grants 0, fifo_count=0, empty=1. After release, push_gnt=4'b0001; pop is not granted.
- push_req=4'b1111 held for 8 cycles, no pops → grants rotate 0,1,2,3,0,1,2,3. fifo_count reaches 8, full=1, then no further push grant.
- At full, push_req=4'b0100 and pop_req=4'b0010 → push_gnt=4'b0100, pop_gnt=4'b0010, fifo_count stays 8.
- At count=1, pop_req=4'b1001 with pointer=3 → pop_gnt=4'b1000. Next cycle empty=1, and the remaining pop_req[0] is not granted.
- Async rst pulsed mid-cycle while count=5 → outputs clear before the next clk edge; count=0 and pointers=0 after release.
- With FIFO_ARB_CHECK_EN defined, a full regression produces no assertion failures and hits all four covers.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared defaults and types for the FIFO access arbiter.
// Assertions and covers are enabled by defining FIFO_ARB_CHECK_EN.
package fifo_arb_pkg;

    localparam int FA_NREQ     = 4;
    localparam int FA_MAXCOUNT = 8;

    typedef logic [FA_NREQ-1:0]         req_vec_t;
    typedef logic [$clog2(FA_NREQ)-1:0] idx_t;

    function automatic int wrap_inc(input int v, input int n);
        return (v == n - 1) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/fifo_access_arbiter_rr.sv
// Single round-robin arbiter: searches upward from ptr, wrapping to 0.
// Optional checks live in the top level under FIFO_ARB_CHECK_EN.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);

    int            j;
    logic [IW-1:0] jj;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        jj    = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            jj = IW'(j);
            if (en && !valid && req[jj]) begin
                valid   = 1'b1;
                gnt[jj] = 1'b1;
                idx     = jj;
            end
        end
    end

endmodule

// File: rtl/fifo_access_arbiter.sv
// Round-robin push/pop arbitration with occupancy tracking for a shared FIFO.
// Define FIFO_ARB_CHECK_EN to compile assertions and covers.
module fifo_access_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NREQ     = FA_NREQ,
    parameter  int MAXCOUNT = FA_MAXCOUNT,
    localparam int CW       = $clog2(MAXCOUNT + 1),
    localparam int IW       = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] push_req,
    input  logic [NREQ-1:0] pop_req,
    output logic [NREQ-1:0] push_gnt,
    output logic [NREQ-1:0] pop_gnt,
    output logic            push,
    output logic            pop,
    output logic [IW-1:0]   push_idx,
    output logic [IW-1:0]   pop_idx,
    output logic            full,
    output logic            empty,
    output logic [CW-1:0]   fifo_count
);

    logic [IW-1:0] push_ptr;
    logic [IW-1:0] pop_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (fifo_count == '0);
    assign full    = (fifo_count == CW'(MAXCOUNT));
    assign pop_ok  = !empty;
    // A full FIFO accepts a push only alongside a granted pop
    assign push_ok = !full || (pop_ok && |pop_req);

    rr_arbiter #(.N(NREQ)) u_push_arb (
        .req   (push_req),
        .en    (push_ok && !rst),
        .ptr   (push_ptr),
        .gnt   (push_gnt),
        .idx   (push_idx),
        .valid (push)
    );

    rr_arbiter #(.N(NREQ)) u_pop_arb (
        .req   (pop_req),
        .en    (pop_ok && !rst),
        .ptr   (pop_ptr),
        .gnt   (pop_gnt),
        .idx   (pop_idx),
        .valid (pop)
    );

`ifdef FIFO_ARB_CHECK_EN
    logic seen_full;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_count <= '0;
            push_ptr   <= '0;
            pop_ptr    <= '0;
`ifdef FIFO_ARB_CHECK_EN
            seen_full  <= 1'b0;
`endif
        end else begin
            if (push) push_ptr <= IW'(wrap_inc(int'(push_idx), NREQ));
            if (pop)  pop_ptr  <= IW'(wrap_inc(int'(pop_idx), NREQ));
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
`ifdef FIFO_ARB_CHECK_EN
            assert ($onehot0(push_gnt))
                else $error("%m push_gnt not one-hot at %0t", $time);
            assert ($onehot0(pop_gnt))
                else $error("%m pop_gnt not one-hot at %0t", $time);
            assert (fifo_count <= CW'(MAXCOUNT))
                else $error("%m count overflow at %0t", $time);
            assert (!(push && full && !pop))
                else $error("%m push into full at %0t", $time);
            assert (!(pop && empty))
                else $error("%m pop from empty at %0t", $time);
            if (full) seen_full <= 1'b1;
            cover (full);
            cover (seen_full && empty);
            cover (push && pop && full);
            cover ((push && push_idx == IW'(NREQ - 1)) ||
                   (pop && pop_idx == IW'(NREQ - 1)));
`endif
        end
    end

endmodule

// File: tb/tb_fifo_access_arbiter.sv
// Scoreboard bench for fifo_access_arbiter (NREQ=4, MAXCOUNT=8).
module tb_fifo_access_arbiter;
    import fifo_arb_pkg::*;

    localparam int MAXC = 8;

    logic       clk;
    logic       rst;
    req_vec_t   push_req;
    req_vec_t   pop_req;
    req_vec_t   push_gnt;
    req_vec_t   pop_gnt;
    logic       push;
    logic       pop;
    idx_t       push_idx;
    idx_t       pop_idx;
    logic       full;
    logic       empty;
    logic [3:0] fifo_count;

    fifo_access_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .push_req   (push_req),
        .pop_req    (pop_req),
        .push_gnt   (push_gnt),
        .pop_gnt    (pop_gnt),
        .push       (push),
        .pop        (pop),
        .push_idx   (push_idx),
        .pop_idx    (pop_idx),
        .full       (full),
        .empty      (empty),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] pg;
        logic [3:0] qg;
        int         cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   m_cnt = 0;
    int   m_pp  = 0;
    int   m_qp  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Rotate the request vector so the pointer sits at bit 0.
    function automatic logic [3:0] rr_pick(input logic [3:0] req,
                                           input int ptr, input bit ok);
        logic [7:0] d;
        d = {req, req} >> ptr;
        if (!ok) return 4'b0;
        for (int k = 0; k < 4; k++)
            if (d[k]) return 4'(1 << ((ptr + k) % 4));
        return 4'b0;
    endfunction

    function automatic int oh2i(input logic [3:0] v);
        for (int k = 0; k < 4; k++) if (v[k]) return k;
        return 0;
    endfunction

    task automatic step(input req_vec_t pr, input req_vec_t qr);
        exp_t e;
        bit   pok;
        bit   qok;
        @(negedge clk);
        push_req = pr;
        pop_req  = qr;
        qok  = (m_cnt > 0);
        pok  = (m_cnt < MAXC) || (qok && (qr != 0));
        e.pg = rr_pick(pr, m_pp, pok);
        e.qg = rr_pick(qr, m_qp, qok);
        e.cnt = m_cnt;
        sb.push_back(e);
        #2;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        chk("push_gnt", 32'(push_gnt), 32'(e.pg));
        chk("pop_gnt", 32'(pop_gnt), 32'(e.qg));
        chk("push", 32'(push), 32'(e.pg != 0));
        chk("pop", 32'(pop), 32'(e.qg != 0));
        chk("push_idx", 32'(push_idx), 32'(oh2i(e.pg)));
        chk("pop_idx", 32'(pop_idx), 32'(oh2i(e.qg)));
        chk("count", 32'(fifo_count), 32'(e.cnt));
        chk("full", 32'(full), 32'(e.cnt == MAXC));
        chk("empty", 32'(empty), 32'(e.cnt == 0));
        if (e.pg != 0) m_pp = (oh2i(e.pg) + 1) % 4;
        if (e.qg != 0) m_qp = (oh2i(e.qg) + 1) % 4;
        if (e.pg != 0 && e.qg == 0) m_cnt++;
        if (e.pg == 0 && e.qg != 0) m_cnt--;
    endtask

    initial begin
        rst      = 1'b1;
        push_req = 4'b1111;
        pop_req  = 4'b1111;
        @(negedge clk);
        #1;
        chk("rst_push_gnt", 32'(push_gnt), 0);
        chk("rst_pop_gnt", 32'(pop_gnt), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        push_req = 4'b0;
        pop_req  = 4'b0;
        rst      = 1'b0;

        step(4'b1111, 4'b1111);
        chk("first_push", 32'(push_gnt), 32'h1);
        chk("first_no_pop", 32'(pop_gnt), 0);

        for (int i = 1; i < 8; i++) begin
            step(4'b1111, 4'b0000);
            chk("rotate", 32'(push_gnt), 32'(1 << (i % 4)));
        end
        step(4'b1111, 4'b0000);
        chk("full_flag", 32'(full), 1);
        chk("full_no_push", 32'(push_gnt), 0);

        step(4'b0100, 4'b0010);
        chk("full_both_push", 32'(push_gnt), 32'h4);
        chk("full_both_pop", 32'(pop_gnt), 32'h2);
        step(4'b0000, 4'b0000);
        chk("full_hold", 32'(fifo_count), 8);

        for (int i = 0; i < 6; i++) step(4'b0000, 4'b1111);
        step(4'b0000, 4'b0100);
        step(4'b0000, 4'b1001);
        chk("ptr3_pop", 32'(pop_gnt), 32'h8);
        step(4'b0000, 4'b0001);
        chk("drain_empty", 32'(empty), 1);
        chk("drain_no_pop", 32'(pop_gnt), 0);

        for (int i = 0; i < 5; i++) step(4'b1111, 4'b0000);
        step(4'b0000, 4'b0000);
        chk("pre_rst_count", 32'(fifo_count), 5);
        push_req = 4'b1111;
        pop_req  = 4'b1111;
        #1 rst = 1'b1;
        #1;
        chk("async_push_gnt", 32'(push_gnt), 0);
        chk("async_pop_gnt", 32'(pop_gnt), 0);
        chk("async_count", 32'(fifo_count), 0);
        chk("async_empty", 32'(empty), 1);
        push_req = 4'b0;
        pop_req  = 4'b0;
        #1 rst = 1'b0;
        m_cnt = 0;
        m_pp  = 0;
        m_qp  = 0;

        step(4'b1111, 4'b1111);
        chk("post_rst_push", 32'(push_gnt), 32'h1);
        chk("post_rst_pop", 32'(pop_gnt), 0);

        for (int i = 0; i < 400; i++)
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        for (int i = 0; i < 12; i++) step(4'b1011, 4'b0000);
        for (int i = 0; i < 12; i++) step(4'b0000, 4'b1101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
